ldtu_frame_scheduler: RTL and testbench

//  Sits downstream of the TMR encoder. Takes each 32-bit encoded word strobed by Load, buffers it
//  in a small FIFO and sequences it onto a valid/ready link as framed packets.

---
 rtl/ldtu_frame_scheduler.sv | 173 +++++++++++++++++
 tb/tb_ldtu_frame_scheduler.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ldtu_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ldtu_frame_scheduler
// Function : Buffers encoded words in a small FIFO and frames them
//            (header / payload / trailer) onto a valid/ready link, idle-filled.
// Revision : 1.0 - initial release
// ============================================================================
module ldtu_frame_scheduler #(
    parameter int          FIFO_DEPTH = 8,
    parameter int          FRAME_LEN  = 50,
    parameter logic [31:0] IDLE_WORD  = 32'hEAAAAAAA
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [31:0] DATA_32,
    input  logic        Load,
    input  logic        out_ready,
    output logic [31:0] DATA_out,
    output logic        out_valid,
    output logic [1:0]  out_type,
    output logic [11:0] frame_id,
    output logic        overflow,
    output logic [7:0]  drop_cnt
);

    localparam int             c_AW    = $clog2(FIFO_DEPTH);
    localparam logic [c_AW:0]  c_DEPTH = (c_AW + 1)'(FIFO_DEPTH);
    localparam logic [15:0]    c_FLEN  = 16'(FRAME_LEN);

    localparam logic [1:0] c_T_IDLE    = 2'b00;
    localparam logic [1:0] c_T_HEADER  = 2'b01;
    localparam logic [1:0] c_T_PAYLOAD = 2'b10;
    localparam logic [1:0] c_T_TRAILER = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PAYLOAD = 2'd1,
        S_TRAILER = 2'd2
    } state_t;

    logic [31:0]     r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            r_overflow;
    logic [7:0]      r_drop_cnt;

    state_t          r_state;
    logic [15:0]     r_pay_cnt;
    logic [15:0]     r_csum;
    logic [31:0]     r_data;
    logic            r_valid;
    logic [1:0]      r_type;
    logic [11:0]     r_fid;

    logic            w_upd;
    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic [31:0]     w_head;
    logic [15:0]     w_fold;

    assign w_upd   = !r_valid || out_ready;
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_DEPTH);
    assign w_pop   = w_upd && (r_state == S_PAYLOAD) && !w_empty;
    // A full FIFO still accepts a word when the same cycle frees a slot.
    assign w_push  = Load && (!w_full || w_pop);
    assign w_drop  = Load && w_full && !w_pop;
    assign w_head  = r_mem[r_rd_ptr];
    assign w_fold  = w_head[31:16] ^ w_head[15:0];

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= DATA_32;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= 8'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_AW + 1)'(1);
                2'b01:   r_count <= r_count - (c_AW + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 8'hFF) begin
                    r_drop_cnt <= r_drop_cnt + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pay_cnt <= 16'd0;
            r_csum    <= 16'd0;
            r_data    <= IDLE_WORD;
            r_valid   <= 1'b0;
            r_type    <= c_T_IDLE;
            r_fid     <= 12'd0;
        end else begin
            r_valid <= 1'b1;
            if (w_upd) begin
                case (r_state)
                    S_IDLE: begin
                        if (!w_empty) begin
                            r_data    <= {4'hD, r_fid, c_FLEN};
                            r_type    <= c_T_HEADER;
                            r_csum    <= 16'd0;
                            r_pay_cnt <= 16'd0;
                            r_state   <= S_PAYLOAD;
                        end else begin
                            r_data <= IDLE_WORD;
                            r_type <= c_T_IDLE;
                        end
                    end
                    S_PAYLOAD: begin
                        if (!w_empty) begin
                            r_data    <= w_head;
                            r_type    <= c_T_PAYLOAD;
                            r_pay_cnt <= r_pay_cnt + 16'd1;
                            r_csum    <= r_csum ^ w_fold;
                            if (r_pay_cnt + 16'd1 == c_FLEN) begin
                                r_state <= S_TRAILER;
                            end
                        end else begin
                            // Filler keeps the link busy and does not count toward the frame.
                            r_data <= IDLE_WORD;
                            r_type <= c_T_IDLE;
                        end
                    end
                    S_TRAILER: begin
                        r_data  <= {4'hE, r_fid, r_csum};
                        r_type  <= c_T_TRAILER;
                        r_fid   <= r_fid + 12'd1;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_data  <= IDLE_WORD;
                        r_type  <= c_T_IDLE;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign DATA_out  = r_data;
    assign out_valid = r_valid;
    assign out_type  = r_type;
    assign frame_id  = r_fid;
    assign overflow  = r_overflow;
    assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ldtu_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_ldtu_frame_scheduler
// Function : Scoreboard bench for ldtu_frame_scheduler (FRAME_LEN=2, depth 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ldtu_frame_scheduler;

    localparam int          c_FL   = 2;
    localparam logic [31:0] c_IDLE = 32'hEAAAAAAA;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] DATA_32 = 32'd0;
    logic        Load = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] DATA_out;
    logic        out_valid;
    logic [1:0]  out_type;
    logic [11:0] frame_id;
    logic        overflow;
    logic [7:0]  drop_cnt;

    ldtu_frame_scheduler #(
        .FIFO_DEPTH (8),
        .FRAME_LEN  (c_FL),
        .IDLE_WORD  (c_IDLE)
    ) u_dut (
        .CLK       (CLK),
        .reset     (reset),
        .DATA_32   (DATA_32),
        .Load      (Load),
        .out_ready (out_ready),
        .DATA_out  (DATA_out),
        .out_valid (out_valid),
        .out_type  (out_type),
        .frame_id  (frame_id),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    always #5 CLK = ~CLK;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [33:0] sb_q [$];
    int          m_cnt = 0;
    logic [11:0] m_fid = 12'd0;
    logic [15:0] m_ck = 16'd0;
    int          fillers = 0;
    logic        mon_in_frame = 1'b0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_data = 32'd0;
    logic [1:0]  prev_type = 2'd0;
    logic [33:0] mon_exp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference framing model: expected non-idle words in link order.
    task automatic sb_model(input logic [31:0] w);
        if (m_cnt == 0) begin
            sb_q.push_back({2'b01, 4'hD, m_fid, 16'(c_FL)});
            m_ck = 16'd0;
        end
        m_ck = m_ck ^ w[31:16] ^ w[15:0];
        sb_q.push_back({2'b10, w});
        m_cnt++;
        if (m_cnt == c_FL) begin
            sb_q.push_back({2'b11, 4'hE, m_fid, m_ck});
            m_fid = m_fid + 12'd1;
            m_cnt = 0;
        end
    endtask

    always @(negedge CLK) begin
        if (!reset && out_valid) begin
            if (prev_hold) begin
                check("hold_data", 64'(DATA_out), 64'(prev_data));
                check("hold_type", 64'(out_type), 64'(prev_type));
            end
            if (out_ready) begin
                if (out_type == 2'b00) begin
                    check("idle_word", 64'(DATA_out), 64'(c_IDLE));
                    if (mon_in_frame) fillers++;
                end else if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_word: got %h type %0d expected none", DATA_out, out_type);
                end else begin
                    mon_exp = sb_q.pop_front();
                    check("stream", 64'({out_type, DATA_out}), 64'(mon_exp));
                    mon_in_frame = (out_type == 2'b01) || (out_type == 2'b10);
                end
            end
            prev_hold = !out_ready;
            prev_data = DATA_out;
            prev_type = out_type;
        end else begin
            prev_hold = 1'b0;
        end
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        Load  = 1'b0;
        sb_q.delete();
        m_cnt = 0;
        m_ck  = 16'd0;
        m_fid = 12'd0;
        mon_in_frame = 1'b0;
        tick;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data",  64'(DATA_out), 64'(c_IDLE));
        check("rst_type",  64'(out_type), 64'd0);
        check("rst_fid",   64'(frame_id), 64'd0);
        check("rst_ovf",   64'(overflow), 64'd0);
        check("rst_drop",  64'(drop_cnt), 64'd0);
        reset = 1'b0;
        tick;
        check("post_rst_valid", 64'(out_valid), 64'd1);
        check("post_rst_idle",  64'({out_type, DATA_out}), 64'({2'b00, c_IDLE}));
    endtask

    task automatic load(input logic [31:0] w);
        Load    = 1'b1;
        DATA_32 = w;
        tick;
        Load    = 1'b0;
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (sb_q.size() != 0 && k < 300) begin
            tick;
            k++;
        end
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: got %0d words pending expected 0", name, sb_q.size());
        end
        repeat (3) tick;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values and idle fill.
        out_ready = 1'b1;
        do_reset;
        repeat (4) tick;
        check("t1_idle", 64'({out_valid, out_type, DATA_out}), 64'({1'b1, 2'b00, c_IDLE}));

        // Back-to-back frame with hand-computed words.
        sb_q.push_back({2'b01, 32'hD0000002});
        sb_q.push_back({2'b10, 32'h12345678});
        sb_q.push_back({2'b10, 32'h0000FFFF});
        sb_q.push_back({2'b11, 32'hE000BBB3});
        m_fid = 12'd1;
        load(32'h12345678);
        load(32'h0000FFFF);
        drain("t2");
        check("t2_fid", 64'(frame_id), 64'd1);

        // Gap between payload words: fillers, not counted.
        fillers = 0;
        sb_model(32'hA5A5_0F0F);
        load(32'hA5A5_0F0F);
        repeat (5) tick;
        sb_model(32'h0123_4567);
        load(32'h0123_4567);
        drain("t3");
        check("t3_fillers", 64'(fillers), 64'd4);
        check("t3_fid", 64'(frame_id), 64'd2);

        // Backpressure: hold output, overflow after 8 stored words.
        do_reset;
        out_ready = 1'b0;
        tick;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) sb_model(32'h1000_0000 + 32'(i * 32'h0101_0011));
            load(32'h1000_0000 + 32'(i * 32'h0101_0011));
        end
        repeat (10) tick;
        check("t4_ovf",  64'(overflow), 64'd1);
        check("t4_drop", 64'(drop_cnt), 64'd2);
        out_ready = 1'b1;
        drain("t4");
        check("t4_fid", 64'(frame_id), 64'd4);

        // Full FIFO in payload with a simultaneous pop: no drop.
        do_reset;
        sb_model(32'hCAFE_0000);
        load(32'hCAFE_0000);
        tick;
        tick;
        check("t5_payload_type", 64'(out_type), 64'd2);
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sb_model(32'h2000_0000 + 32'(i));
            load(32'h2000_0000 + 32'(i));
        end
        out_ready = 1'b1;
        sb_model(32'h3333_4444);
        load(32'h3333_4444);
        check("t5_ovf",  64'(overflow), 64'd0);
        check("t5_drop", 64'(drop_cnt), 64'd0);
        drain("t5");
        check("t5_fid", 64'(frame_id), 64'd5);

        // Reset in the middle of a frame abandons it.
        sb_model(32'hBEEF_0001);
        load(32'hBEEF_0001);
        for (int k = 0; k < 50 && sb_q.size() > 1; k++) tick;
        check("t6_mid_frame", 64'(sb_q.size()), 64'd1);
        do_reset;
        repeat (3) tick;
        check("t6_empty", 64'({out_type, DATA_out}), 64'({2'b00, c_IDLE}));
        sb_model(32'h0F0F_F0F0);
        load(32'h0F0F_F0F0);
        sb_model(32'h1111_2222);
        load(32'h1111_2222);
        drain("t6");
        check("t6_fid", 64'(frame_id), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
